// File: rtl/fetch_queue.sv
// Multi-lane instruction fetch queue: circular buffer accepting up to IN_LANES
// words per cycle and presenting the OUT_LANES oldest words at the head.
module fetch_queue #(
  parameter int WIDTH     = 30,
  parameter int DEPTH     = 8,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(IN_LANES + 1),
  localparam int OW = $clog2(OUT_LANES + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [IW-1:0]              pushCnt,
  input  logic [IN_LANES*WIDTH-1:0]  pushData,
  output logic                       pushAccept,
  input  logic [OW-1:0]              popCnt,
  output logic [OUT_LANES*WIDTH-1:0] outData,
  output logic [OUT_LANES-1:0]       outValid,
  output logic [CW-1:0]              count,
  output logic [CW-1:0]              freeSlots,
  output logic                       queueEmpty,
  output logic                       queueFull,
  output logic                       errSticky
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [CW-1:0]    free_s;
  logic             push_ok_s;
  logic             push_rej_s;
  logic             pop_ok_s;
  logic [CW-1:0]    push_add_s;
  logic [CW-1:0]    pop_sub_s;

  // Room is judged against the registered count only, so a same-cycle pop never frees space.
  always_comb begin
    free_s     = CW'(DEPTH) - count_q;
    push_rej_s = (CW'(pushCnt) > free_s);
    push_ok_s  = (pushCnt != {IW{1'b0}}) && !push_rej_s;
    pop_ok_s   = (CW'(popCnt) <= count_q);
    if (push_ok_s) begin
      push_add_s = CW'(pushCnt);
    end else begin
      push_add_s = {CW{1'b0}};
    end
    if (pop_ok_s) begin
      pop_sub_s = CW'(popCnt);
    end else begin
      pop_sub_s = {CW{1'b0}};
    end
  end

  // Pointer, occupancy and error next-state; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      head_d  = head_q + PW'(pop_sub_s);
      tail_d  = tail_q + PW'(push_add_s);
      count_d = count_q + push_add_s - pop_sub_s;
      if (push_rej_s || !pop_ok_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage write: only accepted lanes touch the array.
  always_ff @(posedge clock) begin
    for (int i = 0; i < IN_LANES; i++) begin
      if (!reset && !flush && push_ok_s && (IW'(i) < pushCnt)) begin
        mem_q[tail_q + PW'(i)] <= pushData[i*WIDTH +: WIDTH];
      end
    end
  end

  // Head-relative read lanes and status outputs.
  always_comb begin
    outData  = {(OUT_LANES*WIDTH){1'b0}};
    outValid = {OUT_LANES{1'b0}};
    for (int i = 0; i < OUT_LANES; i++) begin
      outData[i*WIDTH +: WIDTH] = mem_q[head_q + PW'(i)];
      outValid[i]               = (CW'(i) < count_q);
    end
  end

  assign pushAccept = push_ok_s;
  assign count      = count_q;
  assign freeSlots  = free_s;
  assign queueEmpty = (count_q == {CW{1'b0}});
  assign queueFull  = (count_q == CW'(DEPTH));
  assign errSticky  = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int WIDTH = 30;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  pushCnt;
  logic [59:0] pushData;
  logic        pushAccept;
  logic [1:0]  popCnt;
  logic [59:0] outData;
  logic [1:0]  outValid;
  logic [3:0]  count;
  logic [3:0]  freeSlots;
  logic        queueEmpty;
  logic        queueFull;
  logic        errSticky;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  bit               m_err;
  bit               acc_seen;
  bit               exp_acc;

  fetch_queue #(.WIDTH(30), .DEPTH(8), .IN_LANES(2), .OUT_LANES(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .pushCnt(pushCnt), .pushData(pushData), .pushAccept(pushAccept),
    .popCnt(popCnt), .outData(outData), .outValid(outValid),
    .count(count), .freeSlots(freeSlots),
    .queueEmpty(queueEmpty), .queueFull(queueFull), .errSticky(errSticky)
  );

  always #5 clock = ~clock;

  // One clock of stimulus; the model follows the behavioural queue rules.
  task automatic step(input bit f, input int pc, input int oc,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    flush    = f;
    pushCnt  = pc[1:0];
    popCnt   = oc[1:0];
    pushData = {b, a};
    #1;
    acc_seen = pushAccept;
    exp_acc  = (pc > 0) && (pc <= DEPTH - mq.size());
    @(posedge clock);
    #1;
    if (f) begin
      mq.delete();
    end else begin
      if (pc > 0 && !exp_acc) m_err = 1'b1;
      if (oc > mq.size()) m_err = 1'b1;
      else repeat (oc) void'(mq.pop_front());
      if (exp_acc) begin
        mq.push_back(a);
        if (pc == 2) mq.push_back(b);
      end
    end
    flush   = 1'b0;
    pushCnt = 2'd0;
    popCnt  = 2'd0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    flush   = 1'b0;
    pushCnt = 2'd0;
    popCnt  = 2'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    flush    = 1'b1;
    pushCnt  = 2'd2;
    popCnt   = 2'd1;
    pushData = 60'h123;
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    flush   = 1'b0;
    pushCnt = 2'd0;
    popCnt  = 2'd0;
    mq.delete();
    m_err = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (freeSlots !== 4'd8) begin failures++; $display("FAIL reset_free got=%0d exp=8", freeSlots); end
    checks++; if (queueEmpty !== 1'b1 || queueFull !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", queueEmpty, queueFull); end
    checks++; if (outValid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", outValid); end
    checks++; if (errSticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", errSticky); end
  endtask

  task automatic test_push_basic();
    do_reset();
    step(1'b0, 2, 0, 30'h0AAAAAAA, 30'h1BBBBBBB);
    checks++; if (acc_seen !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", acc_seen); end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", count); end
    checks++; if (outValid !== 2'b11) begin failures++; $display("FAIL basic_valid got=%b exp=11", outValid); end
    checks++; if (outData[29:0] !== 30'h0AAAAAAA) begin failures++; $display("FAIL basic_lane0 got=%h exp=0aaaaaaa", outData[29:0]); end
    checks++; if (outData[59:30] !== 30'h1BBBBBBB) begin failures++; $display("FAIL basic_lane1 got=%h exp=1bbbbbbb", outData[59:30]); end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b0, 2, 0, 30'd1, 30'd2);
    step(1'b0, 2, 0, 30'd3, 30'd4);
    step(1'b0, 2, 0, 30'd5, 30'd6);
    step(1'b0, 1, 0, 30'd7, 30'd0);
    step(1'b0, 2, 0, 30'd8, 30'd9);
    checks++; if (acc_seen !== 1'b0) begin failures++; $display("FAIL ovf_accept got=%b exp=0", acc_seen); end
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL ovf_count got=%0d exp=7", count); end
    checks++; if (errSticky !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", errSticky); end
    step(1'b0, 1, 0, 30'd10, 30'd0);
    checks++; if (acc_seen !== 1'b1) begin failures++; $display("FAIL fill_accept got=%b exp=1", acc_seen); end
    checks++; if (queueFull !== 1'b1 || freeSlots !== 4'd0) begin failures++; $display("FAIL fill_flags got full=%b free=%0d exp 1/0", queueFull, freeSlots); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 2, 0, 30'(2*i), 30'(2*i+1));
    step(1'b0, 2, 2, 30'h111, 30'h222);
    checks++; if (acc_seen !== 1'b0) begin failures++; $display("FAIL fullpp_accept got=%b exp=0", acc_seen); end
    checks++; if (count !== 4'd6) begin failures++; $display("FAIL fullpp_count got=%0d exp=6", count); end
    checks++; if (outData[29:0] !== 30'd2) begin failures++; $display("FAIL fullpp_head got=%0d exp=2", outData[29:0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 2, 0, 30'(100+2*i), 30'(101+2*i));
    for (int i = 0; i < 3; i++) step(1'b0, 0, 2, 30'd0, 30'd0);
    checks++; if (queueEmpty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", queueEmpty); end
    step(1'b0, 2, 0, 30'h3000001, 30'h3000002);
    step(1'b0, 2, 0, 30'h3000003, 30'h3000004);
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", count); end
    checks++; if (outData !== {30'h3000002, 30'h3000001}) begin failures++; $display("FAIL wrap_lanes_a got=%h exp=%h", outData, {30'h3000002, 30'h3000001}); end
    step(1'b0, 0, 1, 30'd0, 30'd0);
    checks++; if (outData !== {30'h3000003, 30'h3000002}) begin failures++; $display("FAIL wrap_lanes_b got=%h exp=%h", outData, {30'h3000003, 30'h3000002}); end
    step(1'b0, 0, 2, 30'd0, 30'd0);
    checks++; if (outData[29:0] !== 30'h3000004 || outValid !== 2'b01) begin failures++; $display("FAIL wrap_last got=%h v=%b exp=3000004 v=01", outData[29:0], outValid); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b0, 1, 0, 30'd1, 30'd0);
    step(1'b0, 0, 2, 30'd0, 30'd0);
    step(1'b0, 2, 0, 30'd2, 30'd3);
    step(1'b0, 2, 0, 30'd4, 30'd5);
    checks++; if (count !== 4'd5 || errSticky !== 1'b1) begin failures++; $display("FAIL flush_pre got cnt=%0d err=%b exp 5/1", count, errSticky); end
    step(1'b1, 2, 1, 30'd6, 30'd7);
    checks++; if (count !== 4'd0 || queueEmpty !== 1'b1) begin failures++; $display("FAIL flush_count got cnt=%0d empty=%b exp 0/1", count, queueEmpty); end
    checks++; if (errSticky !== 1'b1 || outValid !== 2'b00) begin failures++; $display("FAIL flush_err got err=%b v=%b exp 1/00", errSticky, outValid); end
  endtask

  task automatic test_illegal_pop_reset();
    do_reset();
    step(1'b0, 1, 0, 30'h55, 30'd0);
    step(1'b0, 0, 2, 30'd0, 30'd0);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL ipop_count got=%0d exp=1", count); end
    checks++; if (errSticky !== 1'b1) begin failures++; $display("FAIL ipop_err got=%b exp=1", errSticky); end
    checks++; if (outData[29:0] !== 30'h55) begin failures++; $display("FAIL ipop_head got=%h exp=55", outData[29:0]); end
    do_reset();
    checks++; if (errSticky !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL ipop_reset got err=%b cnt=%0d exp 0/0", errSticky, count); end
  endtask

  task automatic test_random();
    int pc, oc;
    bit f;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      f  = ($urandom_range(0, 39) == 0);
      pc = $urandom_range(0, 2);
      oc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2)
                                       : $urandom_range(0, (mq.size() < 2) ? mq.size() : 2);
      step(f, pc, oc, 30'($urandom()), 30'($urandom()));
      checks++; if (acc_seen !== exp_acc) begin failures++; $display("FAIL rnd_accept cyc=%0d got=%b exp=%b", n, acc_seen, exp_acc); end
      checks++; if (count !== 4'(mq.size()) || freeSlots !== 4'(DEPTH - mq.size())) begin
        failures++; $display("FAIL rnd_count cyc=%0d got cnt=%0d free=%0d exp cnt=%0d", n, count, freeSlots, mq.size());
      end
      checks++; if (queueEmpty !== (mq.size() == 0) || queueFull !== (mq.size() == DEPTH) || errSticky !== m_err) begin
        failures++; $display("FAIL rnd_flags cyc=%0d got e=%b f=%b err=%b exp err=%b", n, queueEmpty, queueFull, errSticky, m_err);
      end
      for (int i = 0; i < 2; i++) begin
        checks++; if (outValid[i] !== (i < mq.size())) begin failures++; $display("FAIL rnd_valid cyc=%0d lane=%0d got=%b", n, i, outValid[i]); end
        if (i < mq.size()) begin
          checks++; if (outData[i*WIDTH +: WIDTH] !== mq[i]) begin
            failures++; $display("FAIL rnd_data cyc=%0d lane=%0d got=%h exp=%h", n, i, outData[i*WIDTH +: WIDTH], mq[i]);
          end
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    pushCnt  = 2'd0;
    popCnt   = 2'd0;
    pushData = 60'd0;
    m_err    = 1'b0;
    test_reset();
    test_push_basic();
    test_overflow();
    test_full_pop_push();
    test_wrap();
    test_flush();
    test_illegal_pop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
